// File: rtl/line_cmd_sched.sv
// Round-robin scheduler that shares one line-drawing engine among NREQ command sources.
// Issues one start pulse per accepted command and reports completion or start timeout.
module line_cmd_sched #(
  parameter int NREQ          = 4,
  parameter int START_TIMEOUT = 15,
  localparam int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_x0,
  input  logic [NREQ*7-1:0] req_y0,
  input  logic [NREQ*8-1:0] req_xlen,
  input  logic [NREQ*8-1:0] req_ylen,
  output logic              eng_start,
  output logic [7:0]        eng_x0,
  output logic [6:0]        eng_y0,
  output logic [7:0]        eng_xlen,
  output logic [7:0]        eng_ylen,
  input  logic              eng_running,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic              err_timeout
);

  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  state_t         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] id_q;
  logic [TW-1:0]  timer_q;
  logic           eng_start_q;
  logic [7:0]     eng_x0_q;
  logic [6:0]     eng_y0_q;
  logic [7:0]     eng_xlen_q;
  logic [7:0]     eng_ylen_q;
  logic           done_q;
  logic           err_q;
  logic [IDW-1:0] done_id_q;

  logic [7:0] x0_a   [NREQ];
  logic [6:0] y0_a   [NREQ];
  logic [7:0] xlen_a [NREQ];
  logic [7:0] ylen_a [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign x0_a[gi]   = req_x0[8*gi +: 8];
    assign y0_a[gi]   = req_y0[7*gi +: 7];
    assign xlen_a[gi] = req_xlen[8*gi +: 8];
    assign ylen_a[gi] = req_ylen[8*gi +: 8];
  end

  // Winner search starts at rr_ptr and wraps; grants are held off in the done cycle.
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW:0]   cand_w;
  logic [IDW-1:0] cand;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand_w      = '0;
    cand        = '0;
    if (state_q == S_IDLE && !eng_running && !done_q) begin
      for (int off = 0; off < NREQ; off++) begin
        cand_w = {1'b0, rr_ptr_q} + (IDW+1)'(off);
        if (cand_w >= (IDW+1)'(NREQ)) begin
          cand_w = cand_w - (IDW+1)'(NREQ);
        end
        cand = cand_w[IDW-1:0];
        if (!grant_found && req_valid[cand]) begin
          grant_found = 1'b1;
          grant_id    = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found && rst_n) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      timer_q     <= '0;
      eng_start_q <= 1'b0;
      eng_x0_q    <= '0;
      eng_y0_q    <= '0;
      eng_xlen_q  <= '0;
      eng_ylen_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      done_id_q   <= '0;
    end else begin
      eng_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            eng_x0_q    <= x0_a[grant_id];
            eng_y0_q    <= y0_a[grant_id];
            eng_xlen_q  <= xlen_a[grant_id];
            eng_ylen_q  <= ylen_a[grant_id];
            id_q        <= grant_id;
            eng_start_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          rr_ptr_q <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
          timer_q  <= '0;
          state_q  <= S_WAIT_START;
        end
        S_WAIT_START: begin
          // Compare one below the limit so the registered error lands as the timer reaches it.
          if (eng_running) begin
            state_q <= S_WAIT_DONE;
          end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
            err_q     <= 1'b1;
            done_id_q <= id_q;
            state_q   <= S_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!eng_running) begin
            done_q    <= 1'b1;
            done_id_q <= id_q;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng_start   = eng_start_q;
  assign eng_x0      = eng_x0_q;
  assign eng_y0      = eng_y0_q;
  assign eng_xlen    = eng_xlen_q;
  assign eng_ylen    = eng_ylen_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign done_id     = done_id_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_line_cmd_sched.sv
// Directed bench for line_cmd_sched with a small behavioural line-engine model.
module tb_line_cmd_sched;
  localparam int NREQ = 4;
  localparam int TMO  = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_x0;
  logic [NREQ*7-1:0] req_y0;
  logic [NREQ*8-1:0] req_xlen;
  logic [NREQ*8-1:0] req_ylen;
  logic              eng_start;
  logic [7:0]        eng_x0;
  logic [6:0]        eng_y0;
  logic [7:0]        eng_xlen;
  logic [7:0]        eng_ylen;
  logic              eng_running = 1'b0;
  logic              busy;
  logic              done;
  logic [1:0]        done_id;
  logic              err_timeout;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int done_cnt    = 0;

  line_cmd_sched #(.NREQ(NREQ), .START_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_xlen(req_xlen), .req_ylen(req_ylen),
    .eng_start(eng_start), .eng_x0(eng_x0), .eng_y0(eng_y0), .eng_xlen(eng_xlen),
    .eng_ylen(eng_ylen), .eng_running(eng_running), .busy(busy), .done(done),
    .done_id(done_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Engine: running rises 3 cycles after the start cycle, stays high eng_dur cycles; no reset.
  int eng_dur  = 1;
  bit eng_dead = 1'b0;
  int dly      = 0;
  int run_left = 0;
  always @(posedge clk) begin
    #2;
    if (eng_start && !eng_dead) begin
      dly = 3;
    end else if (dly > 0) begin
      dly = dly - 1;
      if (dly == 0) begin
        eng_running = 1'b1;
        run_left    = eng_dur;
      end
    end else if (run_left > 0) begin
      run_left = run_left - 1;
      if (run_left == 0) eng_running = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("  ok  %s = 0x%0h", tag, got);
    end
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return eng_start;
      1:       return done;
      2:       return err_timeout;
      3:       return |req_ready;
      default: return !busy;
    endcase
  endfunction

  function automatic int ready_id();
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) return i;
    return 15;
  endfunction

  task automatic wait_sig(input int which, input int budget, input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = sig(which);
    end
    check({tag, "_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic set_req(input int i, input logic [7:0] x0, input logic [6:0] y0,
                         input logic [7:0] xl, input logic [7:0] yl);
    req_x0[8*i +: 8]   = x0;
    req_y0[7*i +: 7]   = y0;
    req_xlen[8*i +: 8] = xl;
    req_ylen[8*i +: 8] = yl;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  int t_start, t_prev, base, viol;

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_x0 = '0; req_y0 = '0; req_xlen = '0; req_ylen = '0;
    repeat (3) @(negedge clk);
    $display("reset state");
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_start", 32'(eng_start), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err_timeout), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data", {eng_x0, 1'b0, eng_y0, eng_xlen, eng_ylen}, 32'h0);
    check("rst_done_id", 32'(done_id), 32'h0);
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("txn 1: single command on req 0");
    eng_dur = 4;
    set_req(0, 8'd10, 7'd20, 8'd5, 8'h03);
    req_valid = 4'b0001; #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    t_start = cyc;
    req_valid = '0;
    check("t1_start", 32'(eng_start), 32'h1);
    check("t1_fields", {eng_x0, 1'b0, eng_y0, eng_xlen, eng_ylen}, {8'd10, 1'b0, 7'd20, 8'd5, 8'h03});
    check("t1_busy", 32'(busy), 32'h1);
    @(negedge clk);
    check("t1_start_1cyc", 32'(eng_start), 32'h0);
    wait_sig(1, 40, "t1_done");
    check("t1_done_lat", 32'(cyc - t_start), 32'd8);
    check("t1_done_id", 32'(done_id), 32'd0);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'h0);
    check("t1_idle", 32'(busy), 32'h0);

    $display("txn 2: all requesters valid, fresh pointer");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    eng_dur = 2;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 7'(i + 2), 8'(i + 3), 8'(i + 4));
    req_valid = 4'hF; #1;
    t_prev = cyc;
    check("t2_grant0", 32'(ready_id()), 32'd0);
    check("t2_onehot0", 32'($countones(req_ready)), 32'd1);
    for (int g = 1; g < 5; g++) begin
      wait_sig(3, 40, "t2_grant");
      check("t2_grant_id", 32'(ready_id()), 32'(g % 4));
      check("t2_onehot", 32'($countones(req_ready)), 32'd1);
      check("t2_no_done_with_grant", 32'(done), 32'h0);
      if (g == 1) check("t2_spacing", 32'(cyc - t_prev), 32'd8);
    end
    @(negedge clk);
    req_valid = '0;
    wait_sig(4, 60, "t2_idle");
    @(negedge clk);

    $display("txn 3: engine never starts");
    eng_dead = 1'b1;
    eng_dur  = 3;
    set_req(1, 8'd200, 7'd100, 8'd7, 8'h85);
    set_req(3, 8'd33, 7'd44, 8'd55, 8'h06);
    base = done_cnt;
    req_valid = 4'b1010; #1;
    check("t3_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    t_start = cyc;
    req_valid = 4'b1000;
    eng_dead  = 1'b0;
    check("t3_ylen_pass", 32'(eng_ylen), 32'h85);
    wait_sig(2, 40, "t3_err");
    check("t3_err_lat", 32'(cyc - t_start), 32'(TMO + 1));
    check("t3_err_id", 32'(done_id), 32'd1);
    check("t3_no_done", 32'(done), 32'h0);
    check("t3_next_grant", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = '0;
    check("t3_err_pulse", 32'(err_timeout), 32'h0);
    wait_sig(1, 40, "t3_done");
    check("t3_done_id", 32'(done_id), 32'd3);
    @(negedge clk);
    check("t3_done_count", 32'(done_cnt - base), 32'd1);

    $display("txn 4: zero-length line");
    eng_dur = 1;
    set_req(2, 8'd9, 7'd9, 8'd0, 8'd0);
    req_valid = 4'b0100; #1;
    check("t4_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    t_start = cyc;
    req_valid = '0;
    check("t4_lens", {16'h0, eng_xlen, eng_ylen}, 32'h0);
    wait_sig(1, 40, "t4_done");
    check("t4_done_lat", 32'(cyc - t_start), 32'd5);
    check("t4_done_id", 32'(done_id), 32'd2);
    @(negedge clk);
    check("t4_idle", 32'(busy), 32'h0);

    $display("txn 5: reset during WAIT_DONE");
    eng_dur = 20;
    set_req(0, 8'd77, 7'd66, 8'd55, 8'd44);
    req_valid = 4'b0001; #1;
    check("t5_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b0010;
    repeat (6) @(negedge clk);
    check("t5_running", 32'(eng_running), 32'h1);
    base = done_cnt;
    rst_n = 1'b0; #1;
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_ready", 32'(req_ready), 32'h0);
    check("t5_rst_x0", 32'(eng_x0), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    for (int n = 0; n < 40 && eng_running; n++) begin
      if (req_ready != '0) viol++;
      @(negedge clk);
    end
    check("t5_engine_stopped", 32'(eng_running), 32'h0);
    check("t5_no_grant_running", 32'(viol), 32'd0);
    check("t5_grant_after", 32'(req_ready), 32'h2);
    check("t5_no_abort_done", 32'(done_cnt - base), 32'd0);
    @(negedge clk);
    req_valid = '0;
    eng_dur = 2;
    wait_sig(1, 40, "t5_done");
    check("t5_done_id", 32'(done_id), 32'd1);
    @(negedge clk);

    $display("txn 6: short valid pulse while busy");
    eng_dur = 6;
    req_valid = 4'b0001; #1;
    check("t6_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    req_valid = 4'b0100; #1;
    check("t6_no_grant_busy", 32'(req_ready), 32'h0);
    @(negedge clk);
    req_valid = 4'b1000;
    wait_sig(3, 40, "t6_grant");
    check("t6_grant_id", 32'(ready_id()), 32'd3);
    @(negedge clk);
    req_valid = '0;
    wait_sig(4, 60, "t6_idle");
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
